preg_alloc_ctrl: RTL and testbench

Rename-stage controller that sequences the R10K physical-register free list. It arbitrates up to `N` per-cycle destination-register requests from dispatch against a locally tracked free-register credit count and drives the free list's allocation count. It forwards retirement frees and runs a flush/drain state machine on branch mispredict. It sits between dispatch/rename and `free_list`, and it is the only agent that drives the free list's control inputs.

---
 rtl/preg_alloc_ctrl.sv | 132 +++++++++++++
 tb/tb_preg_alloc_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/preg_alloc_ctrl.sv
// Rename-stage sequencer for the R10K physical-register free list:
// credit-limited in-order grants, retire forwarding, flush/drain recovery.
module preg_alloc_ctrl #(
  parameter int N           = 3,
  parameter int ARCH_REGS   = 32,
  parameter int PHYS_REGS   = 64,
  parameter int RECOVER_LAT = 2,
  localparam int PB = $clog2(PHYS_REGS),
  localparam int CW = $clog2(PHYS_REGS + 1),
  localparam int TW = $clog2(N + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N-1:0]                  dispatch_req,
  output logic [N-1:0]                  grant,
  output logic                          dispatch_ready,
  output logic [N-1:0][PB-1:0]          alloc_pregs,
  input  logic [N-1:0]                  retire_free,
  input  logic [N-1:0][PB-1:0]          retire_pregs,
  input  logic                          branch_mispredict,
  input  logic [ARCH_REGS-1:0][PB-1:0]  arch_map,
  output logic [TW-1:0]                 fl_num_tags,
  output logic [N-1:0]                  fl_free_request,
  output logic [N-1:0][PB-1:0]          fl_retired_pregs,
  output logic                          fl_branch_mispredict,
  output logic [ARCH_REGS-1:0][PB-1:0]  fl_arch_map,
  input  logic [N-1:0][PB-1:0]          fl_allocated_pregs,
  input  logic [N-1:0]                  fl_valid_preg,
  output logic [CW-1:0]                 credits,
  output logic                          busy,
  output logic                          alloc_error
);

  localparam int FREE_INIT = PHYS_REGS - ARCH_REGS;
  localparam int SW = CW + 1;
  localparam int DW = (RECOVER_LAT > 0) ? $clog2(RECOVER_LAT + 1) : 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                         state;
  logic [ARCH_REGS-1:0][PB-1:0]   map_q;
  logic [DW-1:0]                  drain_cnt;

  logic          run;
  logic          take;
  logic [TW-1:0] req_cnt;
  logic [TW-1:0] free_cnt;
  logic [TW-1:0] k;
  logic [TW-1:0] seen;
  logic [SW-1:0] sum;
  logic          over;
  logic          bad_alloc;

  always_comb begin
    run      = (state == RUN);
    take     = run && !branch_mispredict;
    req_cnt  = TW'($countones(dispatch_req));
    free_cnt = TW'($countones(retire_free));
    k        = '0;
    if (take)
      k = (CW'(req_cnt) > credits) ? TW'(credits) : req_cnt;
    // lowest k requesters win, so grants stay in program order
    grant = '0;
    seen  = '0;
    for (int i = 0; i < N; i++) begin
      if (dispatch_req[i] && (seen < k)) begin
        grant[i] = 1'b1;
        seen     = seen + TW'(1);
      end
    end
    dispatch_ready = take && (k == req_cnt);
    fl_num_tags    = k;
    sum  = {1'b0, credits} - SW'(k) + SW'(free_cnt);
    over = (sum > SW'(FREE_INIT));
    bad_alloc = |(grant & ~fl_valid_preg);
  end

  assign alloc_pregs          = fl_allocated_pregs;
  assign fl_free_request      = run ? retire_free : '0;
  assign fl_retired_pregs     = run ? retire_pregs : '0;
  assign fl_branch_mispredict = (state == FLUSH);
  assign fl_arch_map          = (state == FLUSH) ? map_q : '0;
  assign busy                 = !run;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      credits     <= CW'(FREE_INIT);
      map_q       <= '0;
      drain_cnt   <= '0;
      alloc_error <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          credits <= over ? CW'(FREE_INIT) : sum[CW-1:0];
          if (over || bad_alloc)
            alloc_error <= 1'b1;
          if (branch_mispredict) begin
            map_q <= arch_map;
            state <= FLUSH;
          end
        end
        FLUSH: begin
          credits   <= CW'(FREE_INIT);
          drain_cnt <= DW'(RECOVER_LAT);
          if (branch_mispredict)
            map_q <= arch_map;
          else if (RECOVER_LAT == 0)
            state <= RUN;
          else
            state <= DRAIN;
        end
        DRAIN: begin
          if (branch_mispredict) begin
            map_q <= arch_map;
            state <= FLUSH;
          end else if (drain_cnt <= DW'(1)) begin
            state <= RUN;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_preg_alloc_ctrl.sv
// Directed scenarios plus a randomized run against a
// cycle-level reference model of preg_alloc_ctrl.
module tb_preg_alloc_ctrl;

  localparam int N  = 3;
  localparam int AR = 32;
  localparam int PB = 6;
  localparam int CW = 7;
  localparam int TW = 2;
  localparam int FI = 32;
  localparam int RL = 2;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [N-1:0]          dispatch_req;
  logic [N-1:0]          grant;
  logic                  dispatch_ready;
  logic [N-1:0][PB-1:0]  alloc_pregs;
  logic [N-1:0]          retire_free;
  logic [N-1:0][PB-1:0]  retire_pregs;
  logic                  branch_mispredict;
  logic [AR-1:0][PB-1:0] arch_map;
  logic [TW-1:0]         fl_num_tags;
  logic [N-1:0]          fl_free_request;
  logic [N-1:0][PB-1:0]  fl_retired_pregs;
  logic                  fl_branch_mispredict;
  logic [AR-1:0][PB-1:0] fl_arch_map;
  logic [N-1:0][PB-1:0]  fl_allocated_pregs;
  logic [N-1:0]          fl_valid_preg;
  logic [CW-1:0]         credits;
  logic                  busy;
  logic                  alloc_error;

  int checks = 0;
  int errors = 0;

  preg_alloc_ctrl #(
    .N(N), .ARCH_REGS(AR), .PHYS_REGS(64), .RECOVER_LAT(RL)
  ) dut (
    .clock(clock), .reset(reset),
    .dispatch_req(dispatch_req), .grant(grant),
    .dispatch_ready(dispatch_ready), .alloc_pregs(alloc_pregs),
    .retire_free(retire_free), .retire_pregs(retire_pregs),
    .branch_mispredict(branch_mispredict), .arch_map(arch_map),
    .fl_num_tags(fl_num_tags), .fl_free_request(fl_free_request),
    .fl_retired_pregs(fl_retired_pregs),
    .fl_branch_mispredict(fl_branch_mispredict),
    .fl_arch_map(fl_arch_map),
    .fl_allocated_pregs(fl_allocated_pregs),
    .fl_valid_preg(fl_valid_preg),
    .credits(credits), .busy(busy), .alloc_error(alloc_error)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    dispatch_req       = '0;
    retire_free        = '0;
    retire_pregs       = '0;
    branch_mispredict  = 1'b0;
    arch_map           = '0;
    fl_allocated_pregs = '0;
    fl_valid_preg      = '1;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    checks++; if (credits !== 7'd32) begin errors++; $display("FAIL rst_credits got %0d exp 32", credits); end
    checks++; if (grant !== 3'b000 || fl_num_tags !== 2'd0) begin errors++; $display("FAIL rst_grant got %b/%0d exp 000/0", grant, fl_num_tags); end
    checks++; if (dispatch_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", dispatch_ready); end
    checks++; if (busy !== 1'b0 || alloc_error !== 1'b0 || fl_branch_mispredict !== 1'b0) begin errors++; $display("FAIL rst_flags got busy=%b err=%b bm=%b exp 0", busy, alloc_error, fl_branch_mispredict); end
    checks++; if (fl_free_request !== 3'b000 || fl_arch_map !== '0) begin errors++; $display("FAIL rst_fl got %b exp 000 and zero map", fl_free_request); end
    reset = 1'b1;
  endtask

  task automatic test_single_alloc;
    logic [N-1:0][PB-1:0] pv;
    pv = {6'd9, 6'd8, 6'd7};
    dispatch_req = 3'b001;
    fl_allocated_pregs = pv;
    #1;
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL single_grant got %b exp 001", grant); end
    checks++; if (fl_num_tags !== 2'd1) begin errors++; $display("FAIL single_tags got %0d exp 1", fl_num_tags); end
    checks++; if (dispatch_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", dispatch_ready); end
    checks++; if (alloc_pregs !== pv) begin errors++; $display("FAIL single_pregs got %h exp %h", alloc_pregs, pv); end
    tick();
    dispatch_req = '0;
    #1;
    checks++; if (credits !== 7'd31) begin errors++; $display("FAIL single_credits got %0d exp 31", credits); end
    tick();
  endtask

  task automatic test_exhaustion;
    do_reset();
    dispatch_req = 3'b111;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (credits !== 7'd2) begin errors++; $display("FAIL exh_credits got %0d exp 2", credits); end
    checks++; if (grant !== 3'b011 || fl_num_tags !== 2'd2) begin errors++; $display("FAIL exh_partial got %b/%0d exp 011/2", grant, fl_num_tags); end
    checks++; if (dispatch_ready !== 1'b0) begin errors++; $display("FAIL exh_ready got %b exp 0", dispatch_ready); end
    tick();
    checks++; if (credits !== 7'd0) begin errors++; $display("FAIL exh_zero got %0d exp 0", credits); end
    checks++; if (grant !== 3'b000 || dispatch_ready !== 1'b0) begin errors++; $display("FAIL exh_block got %b/%b exp 000/0", grant, dispatch_ready); end
  endtask

  task automatic test_grant_free;
    logic [N-1:0][PB-1:0] rp;
    dispatch_req = '0;
    retire_free = 3'b001;
    retire_pregs = {6'd0, 6'd0, 6'd20};
    tick();
    retire_free = '0;
    #1;
    checks++; if (credits !== 7'd1) begin errors++; $display("FAIL gf_credit1 got %0d exp 1", credits); end
    rp = {6'd12, 6'd11, 6'd13};
    dispatch_req = 3'b111;
    retire_free = 3'b111;
    retire_pregs = rp;
    #1;
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL gf_grant got %b exp 001", grant); end
    checks++; if (fl_free_request !== 3'b111 || fl_retired_pregs !== rp) begin errors++; $display("FAIL gf_free got %b %h exp 111 %h", fl_free_request, fl_retired_pregs, rp); end
    tick();
    idle_inputs();
    #1;
    checks++; if (credits !== 7'd3) begin errors++; $display("FAIL gf_credit3 got %0d exp 3", credits); end
  endtask

  task automatic test_mispredict;
    do_reset();
    for (int i = 0; i < AR; i++) arch_map[i] = PB'(i);
    dispatch_req = 3'b111;
    branch_mispredict = 1'b1;
    #1;
    checks++; if (grant !== 3'b000 || fl_num_tags !== 2'd0 || dispatch_ready !== 1'b0) begin errors++; $display("FAIL mp_c got %b/%0d/%b exp 000/0/0", grant, fl_num_tags, dispatch_ready); end
    tick();
    branch_mispredict = 1'b0;
    arch_map = '0;
    #1;
    checks++; if (fl_branch_mispredict !== 1'b1 || fl_arch_map[5] !== 6'd5) begin errors++; $display("FAIL mp_flush got bm=%b map5=%0d exp 1/5", fl_branch_mispredict, fl_arch_map[5]); end
    checks++; if (busy !== 1'b1 || grant !== 3'b000) begin errors++; $display("FAIL mp_flush_busy got %b/%b exp 1/000", busy, grant); end
    tick();
    retire_free = 3'b111;
    #1;
    checks++; if (credits !== 7'd32 || busy !== 1'b1 || fl_free_request !== 3'b000) begin errors++; $display("FAIL mp_c2 got cr=%0d busy=%b fr=%b exp 32/1/000", credits, busy, fl_free_request); end
    checks++; if (fl_arch_map !== '0 || fl_branch_mispredict !== 1'b0) begin errors++; $display("FAIL mp_clean got bm=%b exp 0 and zero map", fl_branch_mispredict); end
    tick();
    checks++; if (busy !== 1'b1 || grant !== 3'b000 || fl_free_request !== 3'b000) begin errors++; $display("FAIL mp_c3 got busy=%b g=%b fr=%b exp 1/000/000", busy, grant, fl_free_request); end
    tick();
    retire_free = '0;
    #1;
    checks++; if (grant !== 3'b111 || busy !== 1'b0 || credits !== 7'd32) begin errors++; $display("FAIL mp_c4 got g=%b busy=%b cr=%0d exp 111/0/32", grant, busy, credits); end
    tick();
    idle_inputs();
  endtask

  task automatic test_mp_drain;
    do_reset();
    for (int i = 0; i < AR; i++) arch_map[i] = PB'(i);
    dispatch_req = 3'b111;
    branch_mispredict = 1'b1;
    tick();
    branch_mispredict = 1'b0;
    tick();
    branch_mispredict = 1'b1;
    for (int i = 0; i < AR; i++) arch_map[i] = PB'(i ^ 1);
    tick();
    branch_mispredict = 1'b0;
    arch_map = '0;
    #1;
    checks++; if (fl_branch_mispredict !== 1'b1 || fl_arch_map[5] !== 6'd4) begin errors++; $display("FAIL mpd_flush got bm=%b map5=%0d exp 1/4", fl_branch_mispredict, fl_arch_map[5]); end
    tick();
    tick();
    checks++; if (busy !== 1'b1 || grant !== 3'b000) begin errors++; $display("FAIL mpd_c5 got busy=%b g=%b exp 1/000", busy, grant); end
    tick();
    checks++; if (grant !== 3'b111 || busy !== 1'b0) begin errors++; $display("FAIL mpd_c6 got g=%b busy=%b exp 111/0", grant, busy); end
    tick();
    idle_inputs();
  endtask

  task automatic test_errors;
    do_reset();
    dispatch_req = 3'b001;
    fl_valid_preg = 3'b110;
    tick();
    idle_inputs();
    #1;
    checks++; if (alloc_error !== 1'b1) begin errors++; $display("FAIL err_invalid got %b exp 1", alloc_error); end
    tick(); tick(); tick();
    checks++; if (alloc_error !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", alloc_error); end
    do_reset();
    #1;
    checks++; if (alloc_error !== 1'b0) begin errors++; $display("FAIL err_cleared got %b exp 0", alloc_error); end
    retire_free = 3'b001;
    tick();
    retire_free = '0;
    #1;
    checks++; if (credits !== 7'd32 || alloc_error !== 1'b1) begin errors++; $display("FAIL err_clamp got cr=%0d err=%b exp 32/1", credits, alloc_error); end
  endtask

  task automatic test_async_reset;
    do_reset();
    dispatch_req = 3'b001;
    fl_valid_preg = 3'b110;
    tick();
    idle_inputs();
    branch_mispredict = 1'b1;
    tick();
    branch_mispredict = 1'b0;
    tick();
    #1;
    checks++; if (busy !== 1'b1 || alloc_error !== 1'b1 || fl_branch_mispredict !== 1'b0) begin errors++; $display("FAIL ar_drain got busy=%b err=%b bm=%b exp 1/1/0", busy, alloc_error, fl_branch_mispredict); end
    #1;
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || alloc_error !== 1'b0 || dispatch_ready !== 1'b1 || credits !== 7'd32) begin errors++; $display("FAIL ar_async got busy=%b err=%b rdy=%b cr=%0d exp 0/0/1/32", busy, alloc_error, dispatch_ready, credits); end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_random;
    int mcred, mrec, r, k, nc;
    bit merr, run, take;
    logic [N-1:0] eg, rf, v;
    logic [AR-1:0][PB-1:0] mmap;
    do_reset();
    mcred = FI; mrec = 0; merr = 0; mmap = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      r = $urandom_range(0, 3);
      dispatch_req = N'((1 << r) - 1);
      rf = N'($urandom);
      if (mcred + $countones(rf) > FI && $urandom_range(0, 9) != 0) rf = '0;
      retire_free = rf;
      retire_pregs = {PB'($urandom), PB'($urandom), PB'($urandom)};
      branch_mispredict = ($urandom_range(0, 14) == 0);
      for (int i = 0; i < AR; i++) arch_map[i] = PB'($urandom);
      v = ($urandom_range(0, 29) == 0) ? N'($urandom) : 3'b111;
      fl_valid_preg = v;
      run  = (mrec == 0);
      take = run && !branch_mispredict;
      k    = take ? ((r < mcred) ? r : mcred) : 0;
      eg   = N'((1 << k) - 1);
      #1;
      checks++; if (grant !== eg || fl_num_tags !== TW'(k)) begin errors++; $display("FAIL rnd_grant cyc %0d got %b/%0d exp %b/%0d", cyc, grant, fl_num_tags, eg, k); end
      checks++; if (dispatch_ready !== (take && k == r)) begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", cyc, dispatch_ready, take && k == r); end
      checks++; if (fl_free_request !== (run ? rf : 3'b000)) begin errors++; $display("FAIL rnd_free cyc %0d got %b exp %b", cyc, fl_free_request, run ? rf : 3'b000); end
      checks++; if (busy !== !run || fl_branch_mispredict !== (mrec == RL + 1)) begin errors++; $display("FAIL rnd_state cyc %0d got busy=%b bm=%b exp rec=%0d", cyc, busy, fl_branch_mispredict, mrec); end
      checks++; if (credits !== CW'(mcred) || alloc_error !== merr) begin errors++; $display("FAIL rnd_credits cyc %0d got %0d/%b exp %0d/%b", cyc, credits, alloc_error, mcred, merr); end
      checks++; if (fl_arch_map !== ((mrec == RL + 1) ? mmap : '0)) begin errors++; $display("FAIL rnd_map cyc %0d got map5=%0d exp %0d", cyc, fl_arch_map[5], mmap[5]); end
      if (run) begin
        nc = mcred - k + $countones(rf);
        if (nc > FI) begin nc = FI; merr = 1; end
        if ((eg & ~v) != 0) merr = 1;
        mcred = nc;
      end else if (mrec == RL + 1) begin
        mcred = FI;
      end
      if (branch_mispredict) begin
        mmap = arch_map;
        mrec = RL + 1;
      end else if (mrec > 0) begin
        mrec--;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    test_reset();
    test_single_alloc();
    test_exhaustion();
    test_grant_free();
    test_mispredict();
    test_mp_drain();
    test_errors();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
